seg7_scan_ctrl: RTL
===================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a bank of 7-segment digits that share one
//  hex-to-segment decoder and one segment bus. Latches a packed multi-digit hex value,
//  steps through the digits at a fixed slot rate and presents one nibble to the
//  shared decoder per slot. Drives active-low digit anodes, with a blanking gap
//  between slots to suppress ghosting.
// PARAMETERS
//  NDIGITS    4     number of multiplexed digits (2..8)
//  SCAN_DIV   1000  clock cycles per digit slot (>= BLANK_CYC+1)
//  BLANK_CYC  16    cycles at start of each slot with all anodes off (>= 1)
// PORTS
//  clk         in   1           system clock
//  rst         in   1           synchronous active-high reset
//  en          in   1           scan enable; 0 = freeze counters, blank display
//  load        in   1           request to capture value/dp_in into pending regs
//  value       in   4*NDIGITS   packed hex digits, digit i = value[4i+3:4i]
//  dp_in       in   NDIGITS     decimal point per digit, 1 = lit
//  hex         out  4           nibble to shared decoder for current slot
//  an_n        out  NDIGITS     digit anodes, active-low one-hot or all-ones
//  dp_n        out  1           decimal point, active-low
//  frame_done  out  1           1-cycle pulse when digit NDIGITS-1 slot ends
// BEHAVIOUR
//  - Reset: hex=0, an_n=all 1, dp_n=1, frame_done=0; slot counter=0, idx=0,
//    shown/pending regs=0, pending flag=0.
//  - One clock, one synchronous reset. Reset mid-frame aborts the frame immediately:
//    no frame_done, blanked output on the next cycle.
//  - load=1: value/dp_in are copied into pending regs and the pending flag is set.
//    A later load overwrites (last wins). Pending is copied to shown only at a frame
//    boundary, so no frame mixes old and new digits.
//  - Slot counter cnt counts 0..SCAN_DIV-1 while en=1.
//    At cnt==SCAN_DIV-1: cnt->0 and idx increments, wrapping NDIGITS-1 -> 0.
//  - On the wrap: frame_done=1 for that single cycle. If the pending flag is set,
//    shown<=pending and the flag is cleared in the same cycle.
//  - load on the same cycle as the wrap: the new value is captured into pending
//    and is applied at the following boundary.
//  - Registered outputs, latency 1:
//    - hex = shown digit idx.
//    - an_n = all 1 while cnt<BLANK_CYC; otherwise an_n[idx]=0, others 1.
//    - dp_n = ~shown_dp[idx] when the anode is driven, else 1.
//  - en=0: cnt and idx hold, an_n=all 1, dp_n=1, frame_done=0. load is still
//    accepted. Resuming continues from the held cnt/idx.
//  - idx never exceeds NDIGITS-1. cnt width = clog2(SCAN_DIV).
// CONFIGURATION
//  SEG7_SCAN_LZS_EN defined: leading-zero suppression.
//    - Digit i>0 is blanked (its an_n stays 1 for the whole slot) when it and all
//      digits above it are 0 in shown.
//    - Digit 0 is never suppressed.
//    - dp_in of a suppressed digit forces it visible.
//    - Slot timing is unchanged.
//  Not defined: every digit is shown, including leading zeros.
// TESTING  (NDIGITS=4, SCAN_DIV=8, BLANK_CYC=2)
//  1. rst 3 cycles, en=1, load value=16'h1A3F -> per slot: 2 cycles an_n=4'b1111,
//     then 6 cycles with an_n=1110/hex=F, 1101/3, 1011/A, 0111/1 in order.
//     frame_done every 32 cycles.
//  2. Load 16'h1234 mid-frame (idx=1) -> the remaining slots of that frame still
//     show the old digits; the next frame shows 4,3,2,1.
//     load on the wrap cycle -> applied one frame later.
//  3. en=0 for 20 cycles mid-slot -> an_n=1111, cnt/idx frozen, frame_done=0.
//     en=1 -> slot resumes with its residual cycle count.
//  4. rst asserted at idx=2,cnt=5 -> next cycle an_n=1111, hex=0, dp_n=1,
//     frame_done never pulses.
//     After rst: shown=0, so the first frame shows hex=0 on all digits.
//  5. dp_in=4'b0100, value=16'h0000 -> dp_n=0 only during the digit 2 driven window.
//     With SEG7_SCAN_LZS_EN: digits 3 and 1 are blanked, digit 2 is shown (dp
//     forces it), digit 0 is shown.
//  6. value=16'h00F0, SEG7_SCAN_LZS_EN defined -> digits 3,2 blanked, 1 and 0 shown.
//     Undefined -> all four digits shown.

Source files
------------

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: data and display bus of the seven-segment scan controller.
// The master side (system logic) drives enable, load and the packed value;
// the slave side (scan controller) returns the decoder nibble, active-low
// anodes, decimal point and the end-of-frame pulse.
interface seg7_scan_if #(
    parameter int NDIGITS = 4
);
    logic                   en;
    logic                   load;
    logic [4*NDIGITS-1:0]   value;
    logic [NDIGITS-1:0]     dp_in;
    logic [3:0]             hex;
    logic [NDIGITS-1:0]     an_n;
    logic                   dp_n;
    logic                   frame_done;

    modport master (
        output en, load, value, dp_in,
        input  hex, an_n, dp_n, frame_done
    );

    modport slave (
        input  en, load, value, dp_in,
        output hex, an_n, dp_n, frame_done
    );
endinterface : seg7_scan_if

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for NDIGITS seven-segment
// digits sharing one hex decoder. Each digit owns a SCAN_DIV-cycle slot whose
// first BLANK_CYC cycles keep every anode off to suppress ghosting. New values
// are staged in pending registers and only become visible at a frame boundary.
// Optional feature: define SEG7_SCAN_LZS_EN for leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int NDIGITS   = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NDIGITS);

    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [4*NDIGITS-1:0]   r_shown;
    logic [NDIGITS-1:0]     r_shown_dp;
    logic [4*NDIGITS-1:0]   r_pend;
    logic [NDIGITS-1:0]     r_pend_dp;
    logic                   r_pend_flag;
    logic [3:0]             r_hex;
    logic [NDIGITS-1:0]     r_an_n;
    logic                   r_dp_n;
    logic                   r_frame_done;

    logic                   w_slot_end;
    logic                   w_wrap;
    logic                   w_in_blank;
    logic [3:0]             w_digit;
    logic                   w_digit_dp;
    logic [NDIGITS-1:0]     w_lz_mask;
    logic [3:0]             w_hex_nx;
    logic [NDIGITS-1:0]     w_an_nx;
    logic                   w_dp_nx;

    assign w_slot_end = bus.en && (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_wrap     = w_slot_end && (r_idx == IDX_W'(NDIGITS - 1));
    assign w_in_blank = (r_cnt < CNT_W'(BLANK_CYC));
    assign w_digit    = r_shown[4*r_idx +: 4];
    assign w_digit_dp = r_shown_dp[r_idx];

    // Slot position: cnt runs through the slot, idx steps digits; both hold while disabled.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (bus.en) begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_W'(NDIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Pending/shown staging: loads land in pending, pending moves to shown only on the frame wrap.
    always_ff @(posedge clk) begin
        // NOTE: the digit registers are plain flops, so they are reset along
        // with the control state; the first frame after reset shows zeros.
        if (rst) begin
            r_shown     <= '0;
            r_shown_dp  <= '0;
            r_pend      <= '0;
            r_pend_dp   <= '0;
            r_pend_flag <= 1'b0;
        end else begin
            if (w_wrap && r_pend_flag) begin
                r_shown    <= r_pend;
                r_shown_dp <= r_pend_dp;
            end
            // A load on the wrap cycle keeps the flag set so it applies one frame later.
            if (bus.load) begin
                r_pend      <= bus.value;
                r_pend_dp   <= bus.dp_in;
                r_pend_flag <= 1'b1;
            end else if (w_wrap) begin
                r_pend_flag <= 1'b0;
            end
        end
    end

`ifdef SEG7_SCAN_LZS_EN
    // Leading-zero mask: digit i>0 is hidden when it and every digit above it are zero, unless its dp is lit.
    always_comb begin
        logic zero_above;
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        w_lz_mask  = '0;
        zero_above = 1'b1;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (r_shown[4*i +: 4] == 4'h0);
            w_lz_mask[i] = zero_above && !r_shown_dp[i];
        end
    end
`else
    assign w_lz_mask = '0;
`endif

    // Next output values: one anode low outside the blanking window, dp follows the lit anode.
    always_comb begin
        w_hex_nx = w_digit;
        w_an_nx  = '1;
        w_dp_nx  = 1'b1;
        if (bus.en && !w_in_blank && !w_lz_mask[r_idx]) begin
            w_an_nx[r_idx] = 1'b0;
            w_dp_nx        = ~w_digit_dp;
        end
    end

    // Output registers: one cycle of latency; reset blanks the display and drops frame_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hex        <= 4'h0;
            r_an_n       <= '1;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_hex        <= w_hex_nx;
            r_an_n       <= w_an_nx;
            r_dp_n       <= w_dp_nx;
            r_frame_done <= w_wrap;
        end
    end

    assign bus.hex        = r_hex;
    assign bus.an_n       = r_an_n;
    assign bus.dp_n       = r_dp_n;
    assign bus.frame_done = r_frame_done;

endmodule : seg7_scan_ctrl
